// File: rtl/fsx_timing_gen.sv
// rtl/fsx_timing_gen.sv - raster timing generator with scaled coordinates and fetch strobe.
// Define FSX_CSYNC_EN to build the registered composite-sync output.
module fsx_timing_gen #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter logic        HS_POL     = 1'b0,
   parameter logic        VS_POL     = 1'b0,
   parameter int unsigned SCALE_LOG2 = 0,
   parameter int unsigned CNT_W      = 12
) (
   input  logic             clkPixel,
   input  logic             nreset,
   input  logic             enable,
   output logic [CNT_W-1:0] h_count,
   output logic [CNT_W-1:0] v_count,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             hsync,
   output logic             vsync,
   output logic             csync,
   output logic             blank,
   output logic             pixelFetch,
   output logic             lineStart,
   output logic             frameDrawn
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_M1   = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [CNT_W-1:0] SCALE_MASK = CNT_W'((1 << SCALE_LOG2) - 1);

   generate
      if (SCALE_LOG2 > 2 ||
          (H_ACTIVE % (1 << SCALE_LOG2)) != 0 ||
          (V_ACTIVE % (1 << SCALE_LOG2)) != 0) begin : g_bad_cfg
         $error("fsx_timing_gen: SCALE_LOG2 out of range or active size not divisible by scale");
      end
   endgenerate

   logic [CNT_W-1:0] h_nxt;
   logic [CNT_W-1:0] v_nxt;
   logic [CNT_W-1:0] h_nn;
   logic             blank_d;
   logic             hs_act_d;
   logic             vs_act_d;
   logic             fetch_d;
   logic             line_d;
   logic             frame_d;

   // Every registered output is decoded from the position being loaded, so it lines up with h_count.
   always_comb begin
      h_nxt    = h_count + 1'b1;
      v_nxt    = v_count;
      h_nn     = '0;
      fetch_d  = 1'b0;
      if (h_count == H_LAST) begin
         h_nxt = '0;
         v_nxt = (v_count == V_LAST) ? '0 : v_count + 1'b1;
      end
      blank_d  = (h_nxt >= H_ACT) || (v_nxt >= V_ACT);
      hs_act_d = (h_nxt >= HS_START) && (h_nxt <= HS_END);
      vs_act_d = (v_nxt >= VS_START) && (v_nxt <= VS_END);
      line_d   = (h_nxt == '0);
      frame_d  = (h_nxt == '0) && (v_nxt == V_ACT);
      // Strobe looks one position ahead; pixel 0 of line 0 is not prefetched across the frame wrap.
      if (h_nxt == H_LAST) begin
         fetch_d = (v_nxt < V_ACT_M1);
      end else begin
         h_nn    = h_nxt + 1'b1;
         fetch_d = (h_nn < H_ACT) && (v_nxt < V_ACT) && ((h_nn & SCALE_MASK) == '0);
      end
   end

   always_ff @(posedge clkPixel or negedge nreset) begin
      if (!nreset) begin
         h_count    <= '0;
         v_count    <= '0;
         x          <= '0;
         y          <= '0;
         blank      <= 1'b0;
         hsync      <= ~HS_POL;
         vsync      <= ~VS_POL;
         pixelFetch <= 1'b0;
         lineStart  <= 1'b0;
         frameDrawn <= 1'b0;
      end else if (enable) begin
         h_count    <= h_nxt;
         v_count    <= v_nxt;
         x          <= blank_d ? '0 : (h_nxt >> SCALE_LOG2);
         y          <= blank_d ? '0 : (v_nxt >> SCALE_LOG2);
         blank      <= blank_d;
         hsync      <= hs_act_d ? HS_POL : ~HS_POL;
         vsync      <= vs_act_d ? VS_POL : ~VS_POL;
         pixelFetch <= fetch_d;
         lineStart  <= line_d;
         frameDrawn <= frame_d;
      end else begin
         pixelFetch <= 1'b0;
         lineStart  <= 1'b0;
         frameDrawn <= 1'b0;
      end
   end

`ifdef FSX_CSYNC_EN
   always_ff @(posedge clkPixel or negedge nreset) begin
      if (!nreset) begin
         csync <= ~HS_POL;
      end else if (enable) begin
         csync <= (hs_act_d || vs_act_d) ? HS_POL : ~HS_POL;
      end
   end
`else
   assign csync = ~HS_POL;
`endif

endmodule

// File: tb/tb_fsx_timing_gen.sv
// tb/tb_fsx_timing_gen.sv - directed bench: full-size line timing plus a small scaled raster.
module tb_fsx_timing_gen;

   logic clk = 1'b0;
   logic nreset = 1'b0;
   logic enable = 1'b1;

   logic [11:0] h_a, v_a, x_a, y_a;
   logic        hs_a, vs_a, cs_a, bl_a, pf_a, ls_a, fd_a;
   logic [7:0]  h_b, v_b, x_b, y_b;
   logic        hs_b, vs_b, cs_b, bl_b, pf_b, ls_b, fd_b;

   int n_cmp = 0;
   int n_bad = 0;
   int n_en;

   always #5 clk = ~clk;

   // Enabled-edge count since reset; expected raster positions are derived from it.
   always @(posedge clk or negedge nreset) begin
      if (!nreset) n_en <= 0;
      else if (enable) n_en <= n_en + 1;
   end

   fsx_timing_gen dut_a (
      .clkPixel(clk), .nreset(nreset), .enable(enable),
      .h_count(h_a), .v_count(v_a), .x(x_a), .y(y_a),
      .hsync(hs_a), .vsync(vs_a), .csync(cs_a), .blank(bl_a),
      .pixelFetch(pf_a), .lineStart(ls_a), .frameDrawn(fd_a)
   );

   fsx_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .HS_POL(1'b0), .VS_POL(1'b0), .SCALE_LOG2(1), .CNT_W(8)
   ) dut_b (
      .clkPixel(clk), .nreset(nreset), .enable(enable),
      .h_count(h_b), .v_count(v_b), .x(x_b), .y(y_b),
      .hsync(hs_b), .vsync(vs_b), .csync(cs_b), .blank(bl_b),
      .pixelFetch(pf_b), .lineStart(ls_b), .frameDrawn(fd_b)
   );

   localparam logic [55:0] RST_A = {12'd0, 12'd0, 12'd0, 12'd0, 8'b0111_0000};
   localparam logic [39:0] RST_B = {8'd0, 8'd0, 8'd0, 8'd0, 8'b0111_0000};

   task automatic test_reset;
      logic [55:0] obs_a;
      logic [39:0] obs_b;
      nreset = 1'b0;
      enable = 1'b1;
      repeat (3) @(negedge clk);
      obs_a = {h_a, v_a, x_a, y_a, bl_a, hs_a, vs_a, cs_a, pf_a, ls_a, fd_a, 1'b0};
      obs_b = {h_b, v_b, x_b, y_b, bl_b, hs_b, vs_b, cs_b, pf_b, ls_b, fd_b, 1'b0};
      n_cmp++; if (obs_a !== RST_A) begin n_bad++; $display("FAIL reset_a got %h want %h", obs_a, RST_A); end
      n_cmp++; if (obs_b !== RST_B) begin n_bad++; $display("FAIL reset_b got %h want %h", obs_b, RST_B); end
      nreset = 1'b1;
      @(negedge clk);
      n_cmp++; if (h_a !== 12'd1) begin n_bad++; $display("FAIL first_edge_a h got %0d want 1", h_a); end
      n_cmp++; if (h_b !== 8'd1) begin n_bad++; $display("FAIL first_edge_b h got %0d want 1", h_b); end
   endtask

   task automatic test_line_default;
      int h, v, n_ls;
      logic e_bl, e_hs, e_pf;
      n_ls = 0;
      for (int i = 0; i < 800; i++) begin
         h = n_en % 800;
         v = (n_en / 800) % 525;
         e_bl = (h >= 640) || (v >= 480);
         e_hs = !(h >= 656 && h <= 751);
         e_pf = (h < 639 && v < 480) || (h == 799 && v < 479);
         if (ls_a) n_ls++;
         n_cmp++; if (h_a !== 12'(h) || v_a !== 12'(v)) begin n_bad++; $display("FAIL line_a pos got %0d,%0d want %0d,%0d", h_a, v_a, h, v); end
         n_cmp++; if ({bl_a, hs_a} !== {e_bl, e_hs}) begin n_bad++; $display("FAIL line_a blank/hsync at h=%0d got %b%b want %b%b", h, bl_a, hs_a, e_bl, e_hs); end
         n_cmp++; if ({pf_a, ls_a} !== {e_pf, h == 0}) begin n_bad++; $display("FAIL line_a pulses at h=%0d got %b%b want %b%b", h, pf_a, ls_a, e_pf, h == 0); end
         n_cmp++; if (x_a !== (e_bl ? 12'd0 : 12'(h))) begin n_bad++; $display("FAIL line_a x at h=%0d got %0d", h, x_a); end
         @(negedge clk);
      end
      n_cmp++; if (n_ls != 1) begin n_bad++; $display("FAIL line_a linestart_count got %0d want 1", n_ls); end
   endtask

   task automatic test_enable;
      int guard;
      guard = 0;
      while ((n_en % 800) != 100 && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++; if (guard >= 1000) begin n_bad++; $display("FAIL enable_wait timeout got %0d want <1000", guard); end
      n_cmp++; if (h_a !== 12'd100 || pf_a !== 1'b1) begin n_bad++; $display("FAIL enable_pre h/pf got %0d/%b want 100/1", h_a, pf_a); end
      enable = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++; if (h_a !== 12'd100) begin n_bad++; $display("FAIL enable_hold_a h got %0d want 100", h_a); end
         n_cmp++; if (h_b !== 8'(n_en % 24)) begin n_bad++; $display("FAIL enable_hold_b h got %0d want %0d", h_b, n_en % 24); end
         n_cmp++; if ({pf_a, ls_a, fd_a, pf_b, ls_b, fd_b} !== 6'b0) begin n_bad++; $display("FAIL enable_pulses got %b want 000000", {pf_a, ls_a, fd_a, pf_b, ls_b, fd_b}); end
         if (i < 9) @(posedge clk);
      end
      enable = 1'b1;
      @(negedge clk);
      n_cmp++; if (h_a !== 12'd101) begin n_bad++; $display("FAIL enable_resume h got %0d want 101", h_a); end
   endtask

   task automatic test_reset_mid;
      int guard;
      logic [55:0] obs_a;
      logic [39:0] obs_b;
      guard = 0;
      while ((n_en % 312) != 130 && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++; if (guard >= 400) begin n_bad++; $display("FAIL rstmid_wait timeout got %0d want <400", guard); end
      n_cmp++; if ({x_b, y_b, bl_b} !== {8'd5, 8'd2, 1'b0}) begin n_bad++; $display("FAIL rstmid_pre x/y/blank got %0d/%0d/%b want 5/2/0", x_b, y_b, bl_b); end
      nreset = 1'b0;
      #1;
      obs_a = {h_a, v_a, x_a, y_a, bl_a, hs_a, vs_a, cs_a, pf_a, ls_a, fd_a, 1'b0};
      obs_b = {h_b, v_b, x_b, y_b, bl_b, hs_b, vs_b, cs_b, pf_b, ls_b, fd_b, 1'b0};
      n_cmp++; if (obs_a !== RST_A) begin n_bad++; $display("FAIL rstmid_a got %h want %h", obs_a, RST_A); end
      n_cmp++; if (obs_b !== RST_B) begin n_bad++; $display("FAIL rstmid_b got %h want %h", obs_b, RST_B); end
      @(negedge clk);
      nreset = 1'b1;
      @(negedge clk);
      n_cmp++; if ({h_b, v_b} !== {8'd1, 8'd0}) begin n_bad++; $display("FAIL rstmid_restart_b got %0d,%0d want 1,0", h_b, v_b); end
      n_cmp++; if ({h_a, v_a} !== {12'd1, 12'd0}) begin n_bad++; $display("FAIL rstmid_restart_a got %0d,%0d want 1,0", h_a, v_a); end
   endtask

   task automatic test_frames_scaled;
      int h, v, n_fd, fd_first, fd_gap, n_pf1;
      logic e_bl, e_hs, e_vs, e_cs, e_pf;
      n_fd = 0; fd_first = -1; fd_gap = 0; n_pf1 = 0;
      for (int i = 0; i < 624; i++) begin
         h = n_en % 24;
         v = (n_en / 24) % 13;
         e_bl = (h >= 16) || (v >= 8);
         e_hs = !(h >= 18 && h <= 20);
         e_vs = !(v >= 9 && v <= 10);
`ifdef FSX_CSYNC_EN
         e_cs = !(!e_hs || !e_vs);
`else
         e_cs = 1'b1;
`endif
         e_pf = (v < 8 && (h % 2) == 1 && h < 15) || (h == 23 && v < 7);
         if (fd_b) begin
            if (fd_first < 0) fd_first = n_en;
            else fd_gap = n_en - fd_first;
            n_fd++;
         end
         if (pf_b && ((h == 23 && v == 0) || (v == 1 && h < 23))) n_pf1++;
         n_cmp++; if ({h_b, v_b} !== {8'(h), 8'(v)}) begin n_bad++; $display("FAIL frame_b pos got %0d,%0d want %0d,%0d", h_b, v_b, h, v); end
         n_cmp++; if ({x_b, y_b} !== (e_bl ? 16'd0 : {8'(h / 2), 8'(v / 2)})) begin n_bad++; $display("FAIL frame_b xy at %0d,%0d got %0d,%0d", h, v, x_b, y_b); end
         n_cmp++; if ({bl_b, hs_b, vs_b, cs_b} !== {e_bl, e_hs, e_vs, e_cs}) begin n_bad++; $display("FAIL frame_b levels at %0d,%0d got %b want %b", h, v, {bl_b, hs_b, vs_b, cs_b}, {e_bl, e_hs, e_vs, e_cs}); end
         n_cmp++; if ({pf_b, ls_b, fd_b} !== {e_pf, h == 0, h == 0 && v == 8}) begin n_bad++; $display("FAIL frame_b pulses at %0d,%0d got %b want %b", h, v, {pf_b, ls_b, fd_b}, {e_pf, h == 0, h == 0 && v == 8}); end
         @(negedge clk);
      end
      n_cmp++; if (n_fd != 2) begin n_bad++; $display("FAIL frame_b framedrawn_count got %0d want 2", n_fd); end
      n_cmp++; if (fd_first != 192 || fd_gap != 312) begin n_bad++; $display("FAIL frame_b framedrawn_timing got %0d/%0d want 192/312", fd_first, fd_gap); end
      n_cmp++; if (n_pf1 != 16) begin n_bad++; $display("FAIL frame_b fetch_line1 got %0d want 16", n_pf1); end
   endtask

   initial begin
      test_reset();
      test_line_default();
      test_enable();
      test_reset_mid();
      test_frames_scaled();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
